// File: rtl/ca_pkg.sv
// Shared constants and FSM encoding for the 1-D cellular-automaton generation sequencer.
package ca_pkg;

   localparam int unsigned CA_WORDS    = 32;
   localparam int unsigned CA_WORD_W   = 8;
   localparam int unsigned CA_GEN_W    = 16;
   localparam int unsigned CA_N        = CA_WORDS * CA_WORD_W;
   localparam int unsigned CA_SEED_IDX = CA_N / 2;

   typedef logic [2:0] state_t;

   localparam state_t IDLE     = 3'd0;
   localparam state_t COMPUTE  = 3'd1;
   localparam state_t SWAP     = 3'd2;
   localparam state_t PUBLISH  = 3'd3;
   localparam state_t WAIT_ACK = 3'd4;
   localparam state_t PAUSE    = 3'd5;

endpackage

// File: rtl/ca_word_rule.sv
// Applies an elementary (Wolfram) rule to one word of cells, given the two boundary neighbours.
module ca_word_rule
   import ca_pkg::*;
#(
   parameter int unsigned WORD_W = CA_WORD_W
) (
   input  logic [7:0]        rule,
   input  logic [WORD_W-1:0] word,
   input  logic              left_bit,
   input  logic              right_bit,
   output logic [WORD_W-1:0] next_word
);

   // ext[i] is the left neighbour of word bit i, ext[i+1] the cell itself, ext[i+2] its right.
   logic [WORD_W+1:0] ext;

   assign ext = {right_bit, word, left_bit};

   always_comb begin
      next_word = '0;
      for (int i = 0; i < int'(WORD_W); i++) begin
         next_word[i] = rule[{ext[i], ext[i+1], ext[i+2]}];
      end
   end

endmodule

// File: rtl/ca_generation_sequencer.sv
// Steps a 256-cell elementary cellular automaton one word per cycle and publishes each
// generation to the display-copy FSM through a load/ack handshake.
module ca_generation_sequencer
   import ca_pkg::*;
#(
   parameter int unsigned WORDS  = CA_WORDS,
   parameter int unsigned WORD_W = CA_WORD_W,
   parameter int unsigned GEN_W  = CA_GEN_W,
   localparam int unsigned COL_W = $clog2(WORDS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [7:0]        rule,
   input  logic              run,
   input  logic              step,
   input  logic              stop,
   output logic              load,
   input  logic              ack,
   input  logic [COL_W-1:0]  rd_col,
   output logic [WORD_W-1:0] rd_data,
   output logic [GEN_W-1:0]  gen,
   output logic              busy
);

   localparam int unsigned N         = WORDS * WORD_W;
   localparam int unsigned SEED_IDX  = N / 2;
   localparam int unsigned SEED_WORD = SEED_IDX / WORD_W;
   localparam int unsigned SEED_BIT  = SEED_IDX % WORD_W;
   localparam logic [WORD_W-1:0] SEED_MASK = WORD_W'(1) << SEED_BIT;
   localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(WORDS - 1);

   state_t             state_q, state_d;
   logic [COL_W-1:0]   w_q, w_d;
   logic [COL_W-1:0]   w_left, w_right;
   logic [7:0]         rule_q, rule_d;
   logic [GEN_W-1:0]   gen_q, gen_d;
   logic [WORD_W-1:0]  cur_q [WORDS];
   logic [WORD_W-1:0]  nxt_q [WORDS];
   logic [WORD_W-1:0]  word_next;
   logic               seed_en, compute_en, swap_en;

   // Neighbouring words wrap around the ring of WORDS words.
   assign w_left  = (w_q == '0) ? LAST_COL : w_q - COL_W'(1);
   assign w_right = (w_q == LAST_COL) ? '0 : w_q + COL_W'(1);

   ca_word_rule #(
      .WORD_W (WORD_W)
   ) u_word_rule (
      .rule      (rule_q),
      .word      (cur_q[w_q]),
      .left_bit  (cur_q[w_left][WORD_W-1]),
      .right_bit (cur_q[w_right][0]),
      .next_word (word_next)
   );

   always_comb begin
      state_d    = state_q;
      w_d        = w_q;
      rule_d     = rule_q;
      gen_d      = gen_q;
      seed_en    = 1'b0;
      compute_en = 1'b0;
      swap_en    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               rule_d  = rule;
               gen_d   = '0;
               w_d     = '0;
               seed_en = 1'b1;
               state_d = PUBLISH;
            end
         end
         COMPUTE: begin
            compute_en = 1'b1;
            if (w_q == LAST_COL) begin
               w_d     = '0;
               state_d = SWAP;
            end else begin
               w_d = w_q + COL_W'(1);
            end
         end
         SWAP: begin
            swap_en = 1'b1;
            gen_d   = gen_q + GEN_W'(1);
            w_d     = '0;
            state_d = PUBLISH;
         end
         PUBLISH: begin
            state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (ack) begin
               if (stop) begin
                  state_d = IDLE;
               end else if (run) begin
                  state_d = COMPUTE;
               end else begin
                  state_d = PAUSE;
               end
            end
         end
         PAUSE: begin
            if (stop) begin
               state_d = IDLE;
            end else if (step) begin
               state_d = COMPUTE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         w_q     <= '0;
         rule_q  <= '0;
         gen_q   <= '0;
         for (int i = 0; i < int'(WORDS); i++) begin
            cur_q[i] <= '0;
            nxt_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         rule_q  <= rule_d;
         gen_q   <= gen_d;
         if (seed_en) begin
            for (int i = 0; i < int'(WORDS); i++) begin
               cur_q[i] <= (i == int'(SEED_WORD)) ? SEED_MASK : '0;
            end
         end
         if (compute_en) begin
            nxt_q[w_q] <= word_next;
         end
         if (swap_en) begin
            for (int i = 0; i < int'(WORDS); i++) begin
               cur_q[i] <= nxt_q[i];
            end
         end
      end
   end

   assign load    = (state_q == PUBLISH);
   assign busy    = (state_q != IDLE);
   assign gen     = gen_q;
   assign rd_data = cur_q[rd_col];

endmodule

// File: tb/tb_ca_generation_sequencer.sv
// Self-checking bench: randomized rules checked against a cell-level ring model of the automaton.
module tb_ca_generation_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [7:0]  rule;
   logic        run;
   logic        step;
   logic        stop;
   logic        load;
   logic        ack;
   logic [4:0]  rd_col;
   logic [7:0]  rd_data;
   logic [15:0] gen;
   logic        busy;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [7:0]  obs [32];
   logic [255:0] model;

   always #5 clk = ~clk;

   ca_generation_sequencer dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .rule    (rule),
      .run     (run),
      .step    (step),
      .stop    (stop),
      .load    (load),
      .ack     (ack),
      .rd_col  (rd_col),
      .rd_data (rd_data),
      .gen     (gen),
      .busy    (busy)
   );

   // Reference model: one generation of a 256-cell ring, cell by cell.
   function automatic logic [255:0] ca_step(input logic [255:0] s, input logic [7:0] r);
      logic [255:0] n;
      logic [2:0]   idx;
      n = '0;
      for (int c = 0; c < 256; c++) begin
         idx  = {s[(c + 255) % 256], s[c], s[(c + 1) % 256]};
         n[c] = r[idx];
      end
      return n;
   endfunction

   function automatic logic [255:0] seed_state();
      logic [255:0] s;
      s      = '0;
      s[128] = 1'b1;
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start  = 1'b0;
      step   = 1'b0;
      stop   = 1'b0;
      ack    = 1'b0;
      run    = 1'b0;
      rule   = 8'd0;
      rd_col = 5'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   // Leaves the DUT in PUBLISH; rule is scrambled afterwards to show it is not re-sampled.
   task automatic do_start(input logic [7:0] r, input logic rn);
      rule  = r;
      run   = rn;
      start = 1'b1;
      tick();
      start = 1'b0;
      rule  = 8'($urandom);
   endtask

   task automatic wait_load(input int budget, inout int cycles);
      while (load !== 1'b1 && cycles < budget) begin
         tick();
         cycles++;
      end
   endtask

   // Cycles counted from the ack cycle to the cycle showing load.
   task automatic ack_and_wait(output int cycles);
      ack = 1'b1;
      tick();
      ack    = 1'b0;
      cycles = 1;
      wait_load(200, cycles);
   endtask

   task automatic read_words();
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         rd_col = 5'(i);
         #1;
         obs[i] = rd_data;
      end
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_busy: got %b expected 0", busy);
      end
      vectors++;
      if (load !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_load: got %b expected 0", load);
      end
      vectors++;
      if (gen !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_gen: got %0d expected 0", gen);
      end
      read_words();
      for (int i = 0; i < 32; i++) begin
         vectors++;
         if (obs[i] !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_word[%0d]: got %h expected 00", i, obs[i]);
         end
      end
   endtask

   task automatic test_rule90();
      int         cyc;
      logic [7:0] exp;
      do_reset();
      do_start(8'd90, 1'b1);
      vectors++;
      if (load !== 1'b1) begin
         miscompares++;
         $display("FAIL r90_first_load: got %b expected 1", load);
      end
      vectors++;
      if (gen !== 16'd0) begin
         miscompares++;
         $display("FAIL r90_gen0: got %0d expected 0", gen);
      end
      tick();
      vectors++;
      if (load !== 1'b0) begin
         miscompares++;
         $display("FAIL r90_load_width: got %b expected 0", load);
      end
      read_words();
      for (int i = 0; i < 32; i++) begin
         exp = (i == 16) ? 8'h01 : 8'h00;
         vectors++;
         if (obs[i] !== exp) begin
            miscompares++;
            $display("FAIL r90_seed_word[%0d]: got %h expected %h", i, obs[i], exp);
         end
      end
      ack_and_wait(cyc);
      vectors++;
      if (cyc !== 34) begin
         miscompares++;
         $display("FAIL r90_latency: got %0d expected 34", cyc);
      end
      vectors++;
      if (gen !== 16'd1) begin
         miscompares++;
         $display("FAIL r90_gen1: got %0d expected 1", gen);
      end
      tick();
      read_words();
      for (int i = 0; i < 32; i++) begin
         exp = (i == 15) ? 8'h80 : (i == 16) ? 8'h02 : 8'h00;
         vectors++;
         if (obs[i] !== exp) begin
            miscompares++;
            $display("FAIL r90_gen1_word[%0d]: got %h expected %h", i, obs[i], exp);
         end
      end
   endtask

   task automatic test_const_rules();
      logic [7:0] rules [2];
      logic [7:0] exps  [2];
      int         cyc;
      rules = '{8'd0, 8'd255};
      exps  = '{8'h00, 8'hFF};
      for (int k = 0; k < 2; k++) begin
         do_reset();
         do_start(rules[k], 1'b1);
         tick();
         ack_and_wait(cyc);
         vectors++;
         if (gen !== 16'd1) begin
            miscompares++;
            $display("FAIL const_gen rule %0d: got %0d expected 1", rules[k], gen);
         end
         tick();
         read_words();
         for (int i = 0; i < 32; i++) begin
            vectors++;
            if (obs[i] !== exps[k]) begin
               miscompares++;
               $display("FAIL const_word rule %0d [%0d]: got %h expected %h",
                        rules[k], i, obs[i], exps[k]);
            end
         end
      end
   endtask

   task automatic test_rule2_wrap();
      int         cyc;
      logic [7:0] exp;
      do_reset();
      do_start(8'd2, 1'b1);
      tick();
      for (int g = 1; g <= 129; g++) begin
         ack_and_wait(cyc);
         vectors++;
         if (gen !== 16'(g)) begin
            miscompares++;
            $display("FAIL r2_gen: got %0d expected %0d", gen, g);
         end
         tick();
         if (g >= 128) begin
            read_words();
            for (int i = 0; i < 32; i++) begin
               if (g == 128) exp = (i == 0) ? 8'h01 : 8'h00;
               else          exp = (i == 31) ? 8'h80 : 8'h00;
               vectors++;
               if (obs[i] !== exp) begin
                  miscompares++;
                  $display("FAIL r2_gen%0d_word[%0d]: got %h expected %h", g, i, obs[i], exp);
               end
            end
         end
      end
   endtask

   task automatic test_random_rules();
      int         cyc;
      logic [7:0] r;
      for (int t = 0; t < 4; t++) begin
         r = 8'($urandom);
         do_reset();
         do_start(r, 1'b1);
         model = seed_state();
         tick();
         for (int g = 1; g <= 3; g++) begin
            repeat ($urandom_range(0, 5)) tick();
            rule = 8'($urandom);
            ack_and_wait(cyc);
            model = ca_step(model, r);
            vectors++;
            if (cyc !== 34) begin
               miscompares++;
               $display("FAIL rand_latency rule %0d: got %0d expected 34", r, cyc);
            end
            vectors++;
            if (gen !== 16'(g)) begin
               miscompares++;
               $display("FAIL rand_gen rule %0d: got %0d expected %0d", r, gen, g);
            end
            tick();
            read_words();
            for (int i = 0; i < 32; i++) begin
               vectors++;
               if (obs[i] !== model[i*8 +: 8]) begin
                  miscompares++;
                  $display("FAIL rand_word rule %0d gen %0d [%0d]: got %h expected %h",
                           r, g, i, obs[i], model[i*8 +: 8]);
               end
            end
         end
      end
   endtask

   task automatic test_step_mode();
      int         cyc;
      int         loads;
      logic [7:0] r;
      r = 8'($urandom);
      do_reset();
      do_start(r, 1'b0);
      model = seed_state();
      tick();
      ack = 1'b1;
      tick();
      ack   = 1'b0;
      loads = 0;
      for (int c = 0; c < 100; c++) begin
         if (load === 1'b1) loads++;
         ack = (c == 50);
         tick();
      end
      ack = 1'b0;
      vectors++;
      if (loads !== 0) begin
         miscompares++;
         $display("FAIL pause_no_load: got %0d loads expected 0", loads);
      end
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL pause_busy: got %b expected 1", busy);
      end
      step = 1'b1;
      tick();
      step = 1'b0;
      cyc  = 1;
      wait_load(200, cyc);
      model = ca_step(model, r);
      vectors++;
      if (cyc !== 34) begin
         miscompares++;
         $display("FAIL step_latency: got %0d expected 34", cyc);
      end
      tick();
      read_words();
      for (int i = 0; i < 32; i++) begin
         vectors++;
         if (obs[i] !== model[i*8 +: 8]) begin
            miscompares++;
            $display("FAIL step_word[%0d]: got %h expected %h", i, obs[i], model[i*8 +: 8]);
         end
      end
      ack = 1'b1;
      tick();
      ack  = 1'b0;
      stop = 1'b1;
      step = 1'b1;
      tick();
      stop = 1'b0;
      step = 1'b0;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL stop_step_busy: got %b expected 0", busy);
      end
      loads = 0;
      for (int c = 0; c < 40; c++) begin
         if (load === 1'b1) loads++;
         tick();
      end
      vectors++;
      if (loads !== 0) begin
         miscompares++;
         $display("FAIL stop_step_no_load: got %0d loads expected 0", loads);
      end
      vectors++;
      if (gen !== 16'd1) begin
         miscompares++;
         $display("FAIL idle_gen_kept: got %0d expected 1", gen);
      end
   endtask

   task automatic test_withhold_ack();
      int         cyc;
      int         loads;
      logic [7:0] r;
      r = 8'($urandom);
      do_reset();
      do_start(r, 1'b1);
      model = seed_state();
      loads = 1;
      tick();
      for (int c = 0; c < 500; c++) begin
         if (load === 1'b1) loads++;
         tick();
      end
      vectors++;
      if (loads !== 1) begin
         miscompares++;
         $display("FAIL withhold_loads: got %0d expected 1", loads);
      end
      read_words();
      for (int i = 0; i < 32; i++) begin
         vectors++;
         if (obs[i] !== model[i*8 +: 8]) begin
            miscompares++;
            $display("FAIL withhold_word[%0d]: got %h expected %h", i, obs[i], model[i*8 +: 8]);
         end
      end
      // Stop raised mid-compute: the generation still completes and is published.
      ack = 1'b1;
      tick();
      ack = 1'b0;
      repeat (5) tick();
      stop = 1'b1;
      cyc  = 6;
      wait_load(200, cyc);
      model = ca_step(model, r);
      vectors++;
      if (cyc !== 34) begin
         miscompares++;
         $display("FAIL stop_compute_latency: got %0d expected 34", cyc);
      end
      vectors++;
      if (gen !== 16'd1) begin
         miscompares++;
         $display("FAIL stop_compute_gen: got %0d expected 1", gen);
      end
      tick();
      ack = 1'b1;
      tick();
      ack  = 1'b0;
      stop = 1'b0;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL stop_at_ack_busy: got %b expected 0", busy);
      end
      read_words();
      for (int i = 0; i < 32; i++) begin
         vectors++;
         if (obs[i] !== model[i*8 +: 8]) begin
            miscompares++;
            $display("FAIL idle_word[%0d]: got %h expected %h", i, obs[i], model[i*8 +: 8]);
         end
      end
   endtask

   task automatic test_reset_mid_compute();
      int cyc;
      do_reset();
      do_start(8'($urandom_range(1, 254)), 1'b1);
      tick();
      ack_and_wait(cyc);
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      repeat (10) tick();
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_compute_busy: got %b expected 1", busy);
      end
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_busy: got %b expected 0", busy);
      end
      vectors++;
      if (gen !== 16'd0) begin
         miscompares++;
         $display("FAIL abort_gen: got %0d expected 0", gen);
      end
      vectors++;
      if (load !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_load: got %b expected 0", load);
      end
      read_words();
      for (int i = 0; i < 32; i++) begin
         vectors++;
         if (obs[i] !== 8'h00) begin
            miscompares++;
            $display("FAIL abort_word[%0d]: got %h expected 00", i, obs[i]);
         end
      end
   endtask

   task automatic test_start_ignored();
      int cyc;
      do_reset();
      do_start(8'd90, 1'b1);
      model = ca_step(seed_state(), 8'd90);
      tick();
      rule  = 8'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      vectors++;
      if (load !== 1'b0) begin
         miscompares++;
         $display("FAIL start_in_wait_load: got %b expected 0", load);
      end
      ack_and_wait(cyc);
      vectors++;
      if (cyc !== 34) begin
         miscompares++;
         $display("FAIL start_in_wait_latency: got %0d expected 34", cyc);
      end
      vectors++;
      if (gen !== 16'd1) begin
         miscompares++;
         $display("FAIL start_in_wait_gen: got %0d expected 1", gen);
      end
      tick();
      read_words();
      for (int i = 0; i < 32; i++) begin
         vectors++;
         if (obs[i] !== model[i*8 +: 8]) begin
            miscompares++;
            $display("FAIL start_in_wait_word[%0d]: got %h expected %h",
                     i, obs[i], model[i*8 +: 8]);
         end
      end
   endtask

   initial begin
      idle_inputs();
      reset_n = 1'b0;
      test_reset();
      test_rule90();
      test_const_rules();
      test_rule2_wrap();
      test_random_rules();
      test_step_mode();
      test_withhold_ack();
      test_reset_mid_compute();
      test_start_ignored();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: summary not reached within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
